// File: rtl/led_panel_receiver.sv
// HUB75 panel-side receiver: oversamples the panel pins, rebuilds each shifted row and
// replays the two latched rows (top half, then bottom half) as a stream of pixel writes.
module led_panel_receiver #(
   parameter int WIDTH       = 64,
   parameter int ADDR_W      = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     pll_clk,
   input  logic                     reset,
   input  logic [2:0]               led_rgb0,
   input  logic [2:0]               led_rgb1,
   input  logic [ADDR_W-1:0]        led_addr,
   input  logic                     led_blank,
   input  logic                     led_latch,
   input  logic                     led_sclk,
   output logic                     pix_valid,
   input  logic                     pix_ready,
   output logic [$clog2(WIDTH)-1:0] pix_x,
   output logic [ADDR_W:0]          pix_y,
   output logic [2:0]               pix_rgb,
   output logic                     blanked,
   output logic                     col_err,
   output logic                     overrun,
   output logic                     frame_done
);

   // state | meaning
   // IDLE  | collecting columns, waiting for LATCH
   // EMIT  | replaying the held row pair as pixel writes

   localparam int XW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH + 2);
   localparam int SW = ADDR_W + 9;
   localparam int DW = ADDR_W + 6;

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                state;
   logic [SW-1:0]         pins;
   logic [SW-1:0]         syn;
   logic [SW-1:0]         sync_q [SYNC_STAGES];
   logic [DW-1:0]         stage_data;
   logic                  sclk_d;
   logic                  latch_d;
   logic                  sclk_rise;
   logic                  latch_rise;
   logic [WIDTH-1:0][5:0] sr;
   logic [WIDTH-1:0][5:0] sr_nx;
   logic [WIDTH-1:0][5:0] hold;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_nx;
   logic [XW-1:0]         x_inc;

   // {rgb1, rgb0, addr, blank, latch, sclk}: one chain so data and strobes stay aligned
   assign pins    = {led_rgb1, led_rgb0, led_addr, led_blank, led_latch, led_sclk};
   assign syn     = sync_q[SYNC_STAGES-1];
   assign blanked = syn[2];

   always_ff @(posedge pll_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         stage_data <= '0;
         sclk_d     <= 1'b0;
         latch_d    <= 1'b0;
         sclk_rise  <= 1'b0;
         latch_rise <= 1'b0;
      end else begin
         sync_q[0] <= pins;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         // stage_data lines up with the registered rise pulses
         stage_data <= syn[SW-1:3];
         sclk_d     <= syn[0];
         latch_d    <= syn[1];
         sclk_rise  <= syn[0] & ~sclk_d;
         latch_rise <= syn[1] & ~latch_d;
      end
   end

   // A latch in the same cycle as a shift must see the freshly shifted column
   always_comb begin
      sr_nx  = sr;
      cnt_nx = cnt;
      if (sclk_rise) begin
         sr_nx = {stage_data[DW-1 -: 6], sr[WIDTH-1:1]};
         if (cnt != CW'(WIDTH + 1)) cnt_nx = cnt + CW'(1);
      end
   end

   assign x_inc = pix_x + XW'(1);

   always_ff @(posedge pll_clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sr         <= '0;
         hold       <= '0;
         cnt        <= '0;
         pix_valid  <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_rgb    <= '0;
         col_err    <= 1'b0;
         overrun    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         col_err    <= 1'b0;
         overrun    <= 1'b0;
         frame_done <= 1'b0;
         sr         <= sr_nx;
         cnt        <= cnt_nx;
         if (latch_rise) begin
            cnt <= '0;
            if (state == IDLE) begin
               hold      <= sr_nx;
               col_err   <= (cnt_nx != CW'(WIDTH));
               state     <= EMIT;
               pix_valid <= 1'b1;
               pix_x     <= '0;
               pix_y     <= {1'b0, stage_data[ADDR_W-1:0]};
               pix_rgb   <= sr_nx[0][2:0];
            end else begin
               overrun <= 1'b1;
            end
         end
         if (state == EMIT && pix_ready) begin
            if (pix_x == XW'(WIDTH - 1)) begin
               if (pix_y[ADDR_W]) begin
                  pix_valid  <= 1'b0;
                  state      <= IDLE;
                  frame_done <= &pix_y[ADDR_W-1:0];
               end else begin
                  pix_x         <= '0;
                  pix_y[ADDR_W] <= 1'b1;
                  pix_rgb       <= hold[0][5:3];
               end
            end else begin
               pix_x   <= x_inc;
               pix_rgb <= pix_y[ADDR_W] ? hold[x_inc][5:3] : hold[x_inc][2:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_led_panel_receiver.sv
// Bench for led_panel_receiver: drives HUB75 pin waveforms and checks the pixel stream
// against a row model built from the history of shifted columns.
module tb_led_panel_receiver;

   localparam int WIDTH       = 64;
   localparam int ADDR_W      = 5;
   localparam int SYNC_STAGES = 2;
   localparam int XW          = $clog2(WIDTH);
   localparam int PW          = XW + ADDR_W + 4;

   typedef logic [PW-1:0] pix_t;

   logic              pll_clk = 1'b0;
   logic              reset = 1'b1;
   logic [2:0]        led_rgb0 = '0;
   logic [2:0]        led_rgb1 = '0;
   logic [ADDR_W-1:0] led_addr = '0;
   logic              led_blank = 1'b0;
   logic              led_latch = 1'b0;
   logic              led_sclk = 1'b0;
   logic              pix_valid;
   logic              pix_ready = 1'b0;
   logic [XW-1:0]     pix_x;
   logic [ADDR_W:0]   pix_y;
   logic [2:0]        pix_rgb;
   logic              blanked;
   logic              col_err;
   logic              overrun;
   logic              frame_done;

   led_panel_receiver #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .pll_clk(pll_clk), .reset(reset), .led_rgb0(led_rgb0), .led_rgb1(led_rgb1),
      .led_addr(led_addr), .led_blank(led_blank), .led_latch(led_latch), .led_sclk(led_sclk),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
      .pix_rgb(pix_rgb), .blanked(blanked), .col_err(col_err), .overrun(overrun),
      .frame_done(frame_done));

   always #5 pll_clk = ~pll_clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int lat_cyc  = 0;
   int rdy_mode = 0;   // 0 always, 1 toggle, 2 never, 3 random

   always @(posedge pll_clk) cyc = cyc + 1;

   always @(posedge pll_clk) begin
      #1;
      case (rdy_mode)
         0:       pix_ready = 1'b1;
         1:       pix_ready = ~pix_ready;
         2:       pix_ready = 1'b0;
         default: pix_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Observer: records accepted pixels, pulses and stall stability
   pix_t acc_q[$];
   int   col_err_n = 0, overrun_n = 0, fd_n = 0, fd_cyc = 0, last_acc_cyc = 0;
   int   first_valid_cyc = 0, stall_viol = 0;
   logic fd_valid = 1'b0, prev_stall = 1'b0, prev_valid = 1'b0;
   pix_t prev_pix = '0;
   pix_t cur_pix;
   assign cur_pix = {pix_x, pix_y, pix_rgb};

   always @(negedge pll_clk) begin
      if (reset) begin
         prev_stall = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (pix_valid && !prev_valid) first_valid_cyc = cyc;
         if (prev_stall && (!pix_valid || cur_pix != prev_pix)) stall_viol = stall_viol + 1;
         if (pix_valid && pix_ready) begin
            acc_q.push_back(cur_pix);
            last_acc_cyc = cyc;
         end
         if (col_err) col_err_n = col_err_n + 1;
         if (overrun) overrun_n = overrun_n + 1;
         if (frame_done) begin
            fd_n     = fd_n + 1;
            fd_cyc   = cyc;
            fd_valid = pix_valid;
         end
         prev_stall = pix_valid && !pix_ready;
         prev_valid = pix_valid;
         prev_pix   = cur_pix;
      end
   end

   // Model: the row register is always the last WIDTH columns ever shifted since reset
   logic [5:0] hist[$];
   pix_t       exp_q[$];

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < WIDTH; i++) hist.push_back(6'd0);
   endtask

   task automatic build_exp(input logic [ADDR_W-1:0] a);
      logic [5:0] col;
      exp_q.delete();
      for (int h = 0; h < 2; h++)
         for (int x = 0; x < WIDTH; x++) begin
            col = hist[hist.size() - WIDTH + x];
            exp_q.push_back({XW'(x), (h == 1), a, (h == 1) ? col[5:3] : col[2:0]});
         end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge pll_clk);
         #1;
      end
   endtask

   task automatic shift_col(input logic [5:0] c, input bit with_latch);
      led_rgb0 = c[2:0];
      led_rgb1 = c[5:3];
      led_sclk = 1'b0;
      tick(4);
      led_sclk = 1'b1;
      if (with_latch) begin
         led_latch = 1'b1;
         lat_cyc   = cyc;
      end
      hist.push_back(c);
      tick(4);
      led_sclk  = 1'b0;
      led_latch = 1'b0;
   endtask

   task automatic shift_random(input int n);
      logic [5:0] c;
      for (int i = 0; i < n; i++) begin
         c = 6'($urandom_range(0, 63));
         shift_col(c, 1'b0);
      end
   endtask

   task automatic do_latch();
      led_latch = 1'b1;
      lat_cyc   = cyc;
      tick(4);
      led_latch = 1'b0;
      tick(4);
   endtask

   task automatic wait_row(input int base);
      for (int i = 0; i < 3000 && acc_q.size() - base < 2 * WIDTH; i++) tick(1);
      tick(8);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      led_sclk = 1'b0;
      led_latch = 1'b0;
      tick(3);
      reset = 1'b0;
      model_reset();
      tick(2);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(3);
      n_checks++;
      if ({pix_valid, pix_x, pix_y, pix_rgb, blanked, col_err, overrun, frame_done} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got v=%b x=%0d y=%0d rgb=%0d blk=%b ce=%b ov=%b fd=%b want all 0",
                  pix_valid, pix_x, pix_y, pix_rgb, blanked, col_err, overrun, frame_done);
      end
      reset = 1'b0;
      model_reset();
      tick(6);
      n_checks++;
      if (pix_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset pix_valid got %b want 0", pix_valid);
      end
   endtask

   task automatic test_blank();
      led_blank = 1'b1;
      tick(SYNC_STAGES - 1);
      n_checks++;
      if (blanked !== 1'b0) begin
         n_fail++;
         $display("FAIL blank_early got %b want 0", blanked);
      end
      tick(1);
      n_checks++;
      if (blanked !== 1'b1) begin
         n_fail++;
         $display("FAIL blank_latency got %b want 1", blanked);
      end
      led_blank = 1'b0;
      tick(4);
   endtask

   task automatic test_spec_row(input string name, input int mode);
      int base, ce0, ov0, sv0, got;
      logic [2:0] lo;
      rdy_mode = mode;
      led_addr = 5'd5;
      for (int i = 0; i < WIDTH; i++) begin
         lo = 3'(i);
         shift_col({~lo, lo}, 1'b0);
      end
      base = acc_q.size(); ce0 = col_err_n; ov0 = overrun_n; sv0 = stall_viol;
      do_latch();
      build_exp(5'd5);
      wait_row(base);
      got = acc_q.size() - base;
      n_checks++;
      if (got !== 2 * WIDTH) begin
         n_fail++;
         $display("FAIL %s_count got %0d want %0d", name, got, 2 * WIDTH);
      end
      for (int i = 0; i < got && i < 2 * WIDTH; i++) begin
         n_checks++;
         if (acc_q[base + i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s_pixel[%0d] got %h want %h", name, i, acc_q[base + i], exp_q[i]);
         end
      end
      n_checks++;
      if (col_err_n - ce0 !== 0 || overrun_n - ov0 !== 0) begin
         n_fail++;
         $display("FAIL %s_flags col_err %0d overrun %0d want 0 0", name, col_err_n - ce0, overrun_n - ov0);
      end
      n_checks++;
      if (stall_viol - sv0 !== 0) begin
         n_fail++;
         $display("FAIL %s_stall_hold got %0d unstable stalls want 0", name, stall_viol - sv0);
      end
      if (mode == 0) begin
         n_checks++;
         if (first_valid_cyc - lat_cyc !== SYNC_STAGES + 2) begin
            n_fail++;
            $display("FAIL %s_latency got %0d want %0d", name, first_valid_cyc - lat_cyc, SYNC_STAGES + 2);
         end
      end
   endtask

   task automatic test_short_row();
      int base, ce0, got;
      logic [ADDR_W-1:0] a;
      rdy_mode = 3;
      a = ADDR_W'($urandom_range(0, 30));
      led_addr = a;
      shift_random(WIDTH - 1);
      base = acc_q.size(); ce0 = col_err_n;
      do_latch();
      build_exp(a);
      wait_row(base);
      got = acc_q.size() - base;
      n_checks++;
      if (col_err_n - ce0 !== 1) begin
         n_fail++;
         $display("FAIL short_col_err got %0d pulses want 1", col_err_n - ce0);
      end
      n_checks++;
      if (got !== 2 * WIDTH) begin
         n_fail++;
         $display("FAIL short_count got %0d want %0d", got, 2 * WIDTH);
      end
      for (int i = 0; i < got && i < 2 * WIDTH; i++) begin
         n_checks++;
         if (acc_q[base + i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL short_pixel[%0d] got %h want %h", i, acc_q[base + i], exp_q[i]);
         end
      end
   endtask

   task automatic test_overrun();
      int base, ov0, got;
      logic [ADDR_W-1:0] a;
      rdy_mode = 2;
      a = ADDR_W'($urandom_range(0, 30));
      led_addr = a;
      shift_random(WIDTH);
      base = acc_q.size(); ov0 = overrun_n;
      do_latch();
      build_exp(a);
      n_checks++;
      if (pix_valid !== 1'b1 || pix_x !== '0) begin
         n_fail++;
         $display("FAIL ovr_emit_start got v=%b x=%0d want v=1 x=0", pix_valid, pix_x);
      end
      led_addr = ~a;
      shift_random(5);
      do_latch();
      n_checks++;
      if (overrun_n - ov0 !== 1 || acc_q.size() - base !== 0) begin
         n_fail++;
         $display("FAIL ovr_pulse got %0d pulses %0d accepts want 1 0", overrun_n - ov0, acc_q.size() - base);
      end
      rdy_mode = 0;
      wait_row(base);
      tick(40);
      got = acc_q.size() - base;
      n_checks++;
      if (got !== 2 * WIDTH) begin
         n_fail++;
         $display("FAIL ovr_count got %0d want %0d", got, 2 * WIDTH);
      end
      for (int i = 0; i < got && i < 2 * WIDTH; i++) begin
         n_checks++;
         if (acc_q[base + i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL ovr_pixel[%0d] got %h want %h", i, acc_q[base + i], exp_q[i]);
         end
      end
   endtask

   task automatic test_frame_done();
      int base, fd0, got;
      for (int k = 0; k < 2; k++) begin
         rdy_mode = 3;
         led_addr = (k == 0) ? 5'd31 : 5'd30;
         shift_random(WIDTH);
         base = acc_q.size(); fd0 = fd_n;
         do_latch();
         build_exp(led_addr);
         wait_row(base);
         got = acc_q.size() - base;
         n_checks++;
         if (got !== 2 * WIDTH) begin
            n_fail++;
            $display("FAIL fd%0d_count got %0d want %0d", k, got, 2 * WIDTH);
         end
         for (int i = 0; i < got && i < 2 * WIDTH; i++) begin
            n_checks++;
            if (acc_q[base + i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL fd%0d_pixel[%0d] got %h want %h", k, i, acc_q[base + i], exp_q[i]);
            end
         end
         n_checks++;
         if (fd_n - fd0 !== ((k == 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL fd%0d_pulses got %0d want %0d", k, fd_n - fd0, (k == 0) ? 1 : 0);
         end
         if (k == 0) begin
            n_checks++;
            if (fd_cyc !== last_acc_cyc + 1 || fd_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL fd_timing got cyc %0d valid %b want cyc %0d valid 0", fd_cyc, fd_valid, last_acc_cyc + 1);
            end
         end
      end
   endtask

   task automatic test_reset_mid_emit();
      int base, got;
      bit found;
      logic [ADDR_W-1:0] a;
      rdy_mode = 0;
      led_addr = 5'd3;
      shift_random(WIDTH);
      do_latch();
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (pix_valid && pix_x == XW'(10)) found = 1'b1;
         else tick(1);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (!found || pix_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_emit reached_x10 %b pix_valid %b want 1 0", found, pix_valid);
      end
      tick(2);
      reset = 1'b0;
      model_reset();
      tick(4);
      a = ADDR_W'($urandom_range(0, 30));
      led_addr = a;
      shift_random(WIDTH);
      base = acc_q.size();
      do_latch();
      build_exp(a);
      wait_row(base);
      got = acc_q.size() - base;
      n_checks++;
      if (got !== 2 * WIDTH) begin
         n_fail++;
         $display("FAIL rst_fresh_count got %0d want %0d", got, 2 * WIDTH);
      end
      for (int i = 0; i < got && i < 2 * WIDTH; i++) begin
         n_checks++;
         if (acc_q[base + i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rst_fresh_pixel[%0d] got %h want %h", i, acc_q[base + i], exp_q[i]);
         end
      end
   endtask

   // Random row lengths around WIDTH, random back-pressure, some latches coincident with SCLK
   task automatic test_back_to_back();
      int base, ce0, sv0, got, n;
      bit coin;
      logic [5:0] c;
      logic [ADDR_W-1:0] a;
      for (int r = 0; r < 4; r++) begin
         rdy_mode = 3;
         n    = WIDTH - 1 + int'($urandom_range(0, 2));
         coin = (r == 1) || ($urandom_range(0, 1) == 1);
         a    = ADDR_W'($urandom_range(0, 30));
         led_addr = a;
         shift_random(n - 1);
         base = acc_q.size(); ce0 = col_err_n; sv0 = stall_viol;
         c = 6'($urandom_range(0, 63));
         shift_col(c, coin);
         if (coin) tick(4);
         else do_latch();
         build_exp(a);
         wait_row(base);
         got = acc_q.size() - base;
         n_checks++;
         if (got !== 2 * WIDTH) begin
            n_fail++;
            $display("FAIL b2b%0d_count got %0d want %0d", r, got, 2 * WIDTH);
         end
         for (int i = 0; i < got && i < 2 * WIDTH; i++) begin
            n_checks++;
            if (acc_q[base + i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL b2b%0d_pixel[%0d] got %h want %h", r, i, acc_q[base + i], exp_q[i]);
            end
         end
         n_checks++;
         if (col_err_n - ce0 !== ((n != WIDTH) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL b2b%0d_col_err got %0d want %0d (cols %0d)", r, col_err_n - ce0, (n != WIDTH) ? 1 : 0, n);
         end
         n_checks++;
         if (stall_viol - sv0 !== 0) begin
            n_fail++;
            $display("FAIL b2b%0d_stall_hold got %0d want 0", r, stall_viol - sv0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_blank();
      test_spec_row("ready_high", 0);
      test_spec_row("ready_toggle", 1);
      test_short_row();
      test_overrun();
      test_frame_done();
      test_reset_mid_emit();
      apply_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
